sdf_ntt_sequencer: RTL and testbench

- Parameterised frame sequencer for the radix-2 DIF single-path delay-feedback (SDF) NTT pipeline of N = 2^LOG_N points.
- Accepts one input frame through a valid/ready handshake.
- Generates, per stage, the butterfly/bypass select, the twiddle ROM address and the pipeline advance strobe. Flushes the pipeline with self-generated cycles.
- Flags output samples and pulses done at end of frame.
- Sits between the host stream interface and the SDF stage datapath; supersedes fixed-count hand-coded control for arbitrary LOG_N.

---
 rtl/sdf_pkg.sv | 26 ++
 rtl/sdf_stage_ctl.sv | 46 ++++
 rtl/sdf_ntt_sequencer.sv | 102 ++++++++++
 tb/tb_sdf_ntt_sequencer.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sdf_pkg.sv
// Shared state encoding and stage-geometry helpers for the SDF NTT sequencer.
package sdf_pkg;

   typedef enum logic [1:0] {IDLE, LOAD, FLUSH} state_t;

   function automatic int stage_depth(input int log_n, input int s);
      return (1 << log_n) >> (s + 1);
   endfunction

   function automatic int stage_offset(input int log_n, input int bf_lat, input int s);
      int off = 0;
      for (int k = 0; k < s; k++) off += stage_depth(log_n, k) + bf_lat;
      return off;
   endfunction

   function automatic int total_latency(input int log_n, input int bf_lat);
      return stage_offset(log_n, bf_lat, log_n - 1) + stage_depth(log_n, log_n - 1) + bf_lat;
   endfunction

   function automatic logic [31:0] bitrev(input logic [31:0] x, input int w);
      logic [31:0] r = '0;
      for (int i = 0; i < 32; i++) if (i < w) r[w-1-i] = x[i];
      return r;
   endfunction

endpackage

// File: rtl/sdf_stage_ctl.sv
// Per-stage control decode: maps the global pipe count to butterfly select,
// twiddle-valid and twiddle ROM address for stage S.
module sdf_stage_ctl
   import sdf_pkg::*;
#(
   parameter int LOG_N  = 3,
   parameter int BF_LAT = 1,
   parameter int S      = 0
) (
   input  logic [LOG_N+1:0] gcnt,
   input  logic             pipe_en,
   output logic             bf_sel,
   output logic             tw_valid,
   output logic [LOG_N-2:0] tw_addr
);

   localparam int GW    = LOG_N + 2;
   localparam int D_I   = stage_depth(LOG_N, S);
   localparam int LOG_D = LOG_N - S - 1;
   localparam logic [GW-1:0] OFF = GW'(stage_offset(LOG_N, BF_LAT, S));
   localparam logic [GW-1:0] N_C = GW'(1 << LOG_N);
   localparam logic [GW-1:0] D2  = GW'(2 * D_I);
   localparam logic [GW-1:0] ND  = GW'((1 << LOG_N) + D_I);
   localparam logic [GW-1:0] DM  = GW'(D_I - 1);

   logic [GW-1:0] lc;
   logic          active;
   logic          odd_half;

   assign lc = gcnt - OFF;

   // Stage 0 has no offset, so it is active from the first accepted sample.
   generate
      if (S == 0) begin : g_first
         assign active = 1'b1;
      end else begin : g_later
         assign active = (gcnt >= OFF);
      end
   endgenerate

   assign odd_half = lc[LOG_D];
   assign bf_sel   = pipe_en & active & (lc < N_C) & odd_half;
   assign tw_valid = pipe_en & active & ~odd_half & (lc >= D2) & (lc < ND);
   assign tw_addr  = tw_valid ? (LOG_N-1)'((lc & DM) << S) : '0;

endmodule

// File: rtl/sdf_ntt_sequencer.sv
// Frame sequencer for a radix-2 DIF SDF NTT pipeline: load, self-flush, output flagging.
// Optional SDF_BITREV_IDX_EN adds out_idx, the bit-reversed output sample index.
module sdf_ntt_sequencer
   import sdf_pkg::*;
#(
   parameter int LOG_N  = 3,
   parameter int BF_LAT = 1
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       start,
   input  logic                       in_valid,
   output logic                       in_ready,
   output logic                       pipe_en,
   output logic [LOG_N-1:0]           bf_sel,
   output logic [LOG_N*(LOG_N-1)-1:0] tw_addr,
   output logic [LOG_N-1:0]           tw_valid,
   output logic                       out_valid,
   output logic                       out_first,
   output logic                       busy,
   output logic                       done_tick
`ifdef SDF_BITREV_IDX_EN
   ,
   output logic [LOG_N-1:0]           out_idx
`endif
);

   localparam int GW  = LOG_N + 2;
   localparam int TW  = LOG_N - 1;
   localparam int N_I = 1 << LOG_N;
   localparam int L_I = total_latency(LOG_N, BF_LAT);
   localparam logic [GW-1:0] LAST_IN  = GW'(N_I - 1);
   localparam logic [GW-1:0] LAT      = GW'(L_I);
   localparam logic [GW-1:0] OUT_END  = GW'(L_I + N_I);
   localparam logic [GW-1:0] LAST_CNT = GW'(L_I + N_I - 1);

   state_t        state, nstate;
   logic [GW-1:0] gcnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= nstate;
   end

   always_comb begin
      nstate = state;
      case (state)
         IDLE:    if (start) nstate = LOAD;
         LOAD:    if (in_valid && gcnt == LAST_IN) nstate = FLUSH;
         FLUSH:   if (gcnt == LAST_CNT) nstate = IDLE;
         default: nstate = IDLE;
      endcase
   end

   always_comb begin
      in_ready = 1'b0;
      pipe_en  = 1'b0;
      busy     = 1'b0;
      case (state)
         LOAD: begin
            in_ready = 1'b1;
            pipe_en  = in_valid;
            busy     = 1'b1;
         end
         FLUSH: begin
            pipe_en = 1'b1;
            busy    = 1'b1;
         end
         default: ;
      endcase
   end

   // gcnt only moves with pipe_en, so input stalls freeze every decoded output.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                      gcnt <= '0;
      else if (state == IDLE && start) gcnt <= '0;
      else if (pipe_en)                gcnt <= gcnt + 1'b1;
   end

   generate
      for (genvar s = 0; s < LOG_N; s++) begin : g_stage
         sdf_stage_ctl #(.LOG_N(LOG_N), .BF_LAT(BF_LAT), .S(s)) u_stage (
            .gcnt     (gcnt),
            .pipe_en  (pipe_en),
            .bf_sel   (bf_sel[s]),
            .tw_valid (tw_valid[s]),
            .tw_addr  (tw_addr[s*TW +: TW])
         );
      end
   endgenerate

   assign out_valid = pipe_en & (gcnt >= LAT) & (gcnt < OUT_END);
   assign out_first = pipe_en & (gcnt == LAT);
   assign done_tick = pipe_en & (gcnt == LAST_CNT);

`ifdef SDF_BITREV_IDX_EN
   logic [GW-1:0] k;
   assign k       = gcnt - LAT;
   assign out_idx = out_valid ? LOG_N'(bitrev(32'(k), LOG_N)) : '0;
`endif

endmodule

// File: tb/tb_sdf_ntt_sequencer.sv
// Randomised bench for sdf_ntt_sequencer with a count-based reference model and literal trace pins.
module tb_sdf_ntt_sequencer;

   localparam int LOG_N = 3;
   localparam int BFL   = 1;
   localparam int NN    = 1 << LOG_N;
   localparam int TW    = LOG_N - 1;

   function automatic int offset(input int s);
      int t = 0;
      for (int k = 0; k < s; k++) t += (NN >> (k + 1)) + BFL;
      return t;
   endfunction

   function automatic int lat();
      int t = 0;
      for (int s = 0; s < LOG_N; s++) t += (NN >> (s + 1)) + BFL;
      return t;
   endfunction

   localparam int LL = lat();

   logic clk, rst_n, start, in_valid;
   logic in_ready, pipe_en, out_valid, out_first, busy, done_tick;
   logic [LOG_N-1:0] bf_sel, tw_valid;
   logic [LOG_N*TW-1:0] tw_addr;
`ifdef SDF_BITREV_IDX_EN
   logic [LOG_N-1:0] out_idx;
`endif

   sdf_ntt_sequencer #(.LOG_N(LOG_N), .BF_LAT(BFL)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .pipe_en   (pipe_en),
      .bf_sel    (bf_sel),
      .tw_addr   (tw_addr),
      .tw_valid  (tw_valid),
      .out_valid (out_valid),
      .out_first (out_first),
      .busy      (busy),
      .done_tick (done_tick)
`ifdef SDF_BITREV_IDX_EN
      ,
      .out_idx   (out_idx)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: phase 0 idle, 1 load, 2 flush; m_cnt counts advancing cycles.
   int m_st = 0;
   int m_cnt = 0;
   int pe_count = 0;
   int d, lc;
   logic e_pe, e_ov, e_of, e_dn;
   logic [LOG_N-1:0] e_bf, e_tw, e_idx;
   logic [LOG_N*TW-1:0] e_ad;
   logic [LOG_N-1:0] tr_bf[0:31];
   logic [LOG_N-1:0] tr_tw[0:31];
   logic [LOG_N*TW-1:0] tr_ad[0:31];
   logic tr_ov[0:31];
   logic tr_dn[0:31];
   int idx_q[$];

   always @(negedge clk) begin
      if (!rst_n) begin
         m_st  = 0;
         m_cnt = 0;
      end
      e_pe = (m_st == 1 && in_valid) || m_st == 2;
      e_bf = '0; e_tw = '0; e_ad = '0; e_idx = '0;
      e_ov = 1'b0; e_of = 1'b0; e_dn = 1'b0;
      if (e_pe) begin
         for (int s = 0; s < LOG_N; s++) begin
            d  = NN >> (s + 1);
            lc = m_cnt - offset(s);
            if (lc >= 0 && lc < NN && (lc / d) % 2 == 1) e_bf[s] = 1'b1;
            if (lc >= 2 * d && lc < NN + d && (lc / d) % 2 == 0) begin
               e_tw[s] = 1'b1;
               e_ad[s*TW +: TW] = TW'((lc % d) << s);
            end
         end
         e_ov = (m_cnt >= LL && m_cnt < LL + NN);
         e_of = (m_cnt == LL);
         e_dn = (m_cnt == LL + NN - 1);
         if (e_ov) begin
            for (int b = 0; b < LOG_N; b++)
               if (((m_cnt - LL) >> b) & 1) e_idx[LOG_N-1-b] = 1'b1;
         end
      end
      chk("in_ready",  64'(in_ready),  64'(m_st == 1));
      chk("busy",      64'(busy),      64'(m_st != 0));
      chk("pipe_en",   64'(pipe_en),   64'(e_pe));
      chk("bf_sel",    64'(bf_sel),    64'(e_bf));
      chk("tw_valid",  64'(tw_valid),  64'(e_tw));
      chk("tw_addr",   64'(tw_addr),   64'(e_ad));
      chk("out_valid", 64'(out_valid), 64'(e_ov));
      chk("out_first", 64'(out_first), 64'(e_of));
      chk("done_tick", 64'(done_tick), 64'(e_dn));
`ifdef SDF_BITREV_IDX_EN
      chk("out_idx",   64'(out_idx),   64'(e_idx));
      if (out_valid) idx_q.push_back(int'(out_idx));
`endif
      if (pipe_en === 1'b1) begin
         pe_count++;
         if (m_cnt < 32) begin
            tr_bf[m_cnt] = bf_sel;
            tr_tw[m_cnt] = tw_valid;
            tr_ad[m_cnt] = tw_addr;
            tr_ov[m_cnt] = out_valid;
            tr_dn[m_cnt] = done_tick;
         end
      end
      if (rst_n) begin
         case (m_st)
            0: if (start) begin
               m_st = 1;
               m_cnt = 0;
               pe_count = 0;
               idx_q.delete();
               for (int g = 0; g < 32; g++) begin
                  tr_bf[g] = '0; tr_tw[g] = '0; tr_ad[g] = '0;
                  tr_ov[g] = 1'b0; tr_dn[g] = 1'b0;
               end
            end
            1: if (in_valid) begin
               if (m_cnt == NN - 1) m_st = 2;
               m_cnt++;
            end
            default: begin
               if (m_cnt == NN + LL - 1) m_st = 0;
               m_cnt++;
            end
         endcase
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Hand-derived traces for LOG_N=3, BF_LAT=1, indexed by advancing-cycle count.
   task automatic check_literals();
      logic [17:0] m0, m1, m2, t0, t1, ov, dn;
      logic [7:0]  a0, a1;
      int exp_idx[8] = '{0, 4, 2, 6, 1, 5, 3, 7};
      for (int g = 0; g < 18; g++) begin
         m0[g] = tr_bf[g][0]; m1[g] = tr_bf[g][1]; m2[g] = tr_bf[g][2];
         t0[g] = tr_tw[g][0]; t1[g] = tr_tw[g][1];
         ov[g] = tr_ov[g];    dn[g] = tr_dn[g];
      end
      a0 = {tr_ad[8][1:0], tr_ad[9][1:0], tr_ad[10][1:0], tr_ad[11][1:0]};
      a1 = {tr_ad[9][3:2], tr_ad[10][3:2], tr_ad[13][3:2], tr_ad[14][3:2]};
      chk("lit_bf0",    64'(m0), 64'h000F0);
      chk("lit_bf1",    64'(m1), 64'h01980);
      chk("lit_bf2",    64'(m2), 64'h0AA00);
      chk("lit_tw0",    64'(t0), 64'h00F00);
      chk("lit_tw1",    64'(t1), 64'h06600);
      chk("lit_addr0",  64'(a0), 64'h1B);
      chk("lit_addr1",  64'(a1), 64'h22);
      chk("lit_outv",   64'(ov), 64'h3FC00);
      chk("lit_done",   64'(dn), 64'h20000);
      chk("frame_cycles", 64'(pe_count), 64'd18);
`ifdef SDF_BITREV_IDX_EN
      chk("idx_count", 64'(idx_q.size()), 64'd8);
      for (int i = 0; i < 8; i++)
         if (i < idx_q.size()) chk("lit_idx", 64'(idx_q[i]), 64'(exp_idx[i]));
`endif
   endtask

   // mode 0: in_valid held; 1: 1,0,0,1 pattern; 2: random + start pulse in FLUSH; 3: random.
   task automatic run_frame(input int mode);
      bit finished = 0;
      bit pulsed = 0;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 400 && !finished; i++) begin
         case (mode)
            0:       in_valid = 1'b1;
            1:       in_valid = (i % 4 == 0) || (i % 4 == 3);
            default: in_valid = ($urandom_range(0, 9) < 7);
         endcase
         start = 1'b0;
         if (mode == 2 && !pulsed && busy && !in_ready) begin
            start  = 1'b1;
            pulsed = 1;
         end
         tick();
         if (!busy) finished = 1;
      end
      in_valid = 1'b0;
      start    = 1'b0;
      if (!finished) begin
         errors++;
         $display("FAIL frame_timeout: mode %0d did not return to idle", mode);
      end
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; in_valid = 1'b0;
      #3;
      chk("reset_outputs", 64'({in_ready, pipe_en, busy, out_valid, out_first, done_tick,
                                bf_sel, tw_valid, tw_addr}), 64'd0);
      tick(); tick();
      rst_n = 1'b1;
      tick();

      run_frame(0); check_literals();
      run_frame(1); check_literals();
      run_frame(2); check_literals();
      run_frame(0); check_literals();

      // Reset in the middle of a loading frame.
      start = 1'b1; tick(); start = 1'b0; in_valid = 1'b1;
      for (int i = 0; i < 50 && m_cnt != 6; i++) tick();
      chk("reached_gcnt6", 64'(m_cnt), 64'd6);
      chk("pre_rst_bf", 64'(bf_sel), 64'h1);
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_outputs", 64'({in_ready, pipe_en, busy, out_valid, out_first, done_tick,
                                    bf_sel, tw_valid, tw_addr}), 64'd0);
      tick();
      rst_n = 1'b1;
      in_valid = 1'b0;
      tick();
      run_frame(0); check_literals();

      for (int f = 0; f < 6; f++) begin
         for (int g = 0; g < int'($urandom_range(0, 3)); g++) tick();
         run_frame(3);
         check_literals();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
